// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, reads instruction memory combinationally and
// registers each returned word into the IF/ID register toward decode.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          MEM_BYTES = 1024
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] pc_addr,
  input  logic [31:0] inst_in,
  input  logic        pc_en_in,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  input  logic        id_ready,
  output logic        id_valid,
  output logic [31:0] id_inst,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc_plus4,
  output logic        halted,
  output logic        fault,
  output logic [31:0] fetch_count
);

  localparam logic [31:0] LAST_PC = 32'(MEM_BYTES - 4);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    HALT  = 2'd1,
    FAULT = 2'd2
  } state_t;

  state_t      state_reg, state_next;
  logic [31:0] pc_reg, pc_next;
  logic        id_valid_reg, id_valid_next;
  logic [31:0] id_inst_reg, id_pc_reg, id_pc_plus4_reg, fetch_count_reg;

  logic        advance;
  logic        out_of_range;
  logic        take_redirect;
  logic        capture;
  logic [31:0] aligned_target;

  assign advance        = !id_valid_reg || id_ready;
  assign out_of_range   = (pc_reg > LAST_PC);
  assign aligned_target = redirect_target & ~32'h0000_0003;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= RUN;
    end else begin
      state_reg <= state_next;
    end
  end

  // Redirect outranks both stop conditions; FAULT only leaves through reset.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      RUN: begin
        if (!redirect_valid) begin
          if (out_of_range) begin
            state_next = FAULT;
          end else if (!pc_en_in) begin
            state_next = HALT;
          end
        end
      end
      HALT: begin
        if (redirect_valid) begin
          state_next = RUN;
        end
      end
      default: state_next = state_reg;
    endcase
  end

  always_comb begin
    take_redirect = 1'b0;
    capture       = 1'b0;
    case (state_reg)
      RUN: begin
        if (redirect_valid) begin
          take_redirect = 1'b1;
        end else if (!out_of_range && pc_en_in && advance) begin
          capture = 1'b1;
        end
      end
      HALT:    take_redirect = redirect_valid;
      default: ;
    endcase
    halted = (state_reg == HALT);
    fault  = (state_reg == FAULT);
  end

  // Without a capture a pending word only drains; a redirect flushes it.
  always_comb begin
    pc_next       = pc_reg;
    id_valid_next = id_valid_reg && !id_ready;
    if (take_redirect) begin
      pc_next       = aligned_target;
      id_valid_next = 1'b0;
    end else if (capture) begin
      pc_next       = pc_reg + 32'd4;
      id_valid_next = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_reg          <= RESET_PC;
      id_valid_reg    <= 1'b0;
      id_inst_reg     <= 32'h0;
      id_pc_reg       <= 32'h0;
      id_pc_plus4_reg <= 32'h0;
      fetch_count_reg <= 32'h0;
    end else begin
      pc_reg       <= pc_next;
      id_valid_reg <= id_valid_next;
      if (capture) begin
        id_inst_reg     <= inst_in;
        id_pc_reg       <= pc_reg;
        id_pc_plus4_reg <= pc_reg + 32'd4;
        fetch_count_reg <= fetch_count_reg + 32'd1;
      end
    end
  end

  assign pc_addr     = pc_reg;
  assign id_valid    = id_valid_reg;
  assign id_inst     = id_inst_reg;
  assign id_pc       = id_pc_reg;
  assign id_pc_plus4 = id_pc_plus4_reg;
  assign fetch_count = fetch_count_reg;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios plus a randomized run
// checked against a cycle-level model of the fetch rules.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_addr, inst_in;
  logic        pc_en_in;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        id_ready;
  logic        id_valid;
  logic [31:0] id_inst, id_pc, id_pc_plus4;
  logic        halted, fault;
  logic [31:0] fetch_count;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] mem [0:255];

  // Model state
  logic [31:0] m_pc, m_inst, m_id_pc, m_plus4, m_count;
  logic        m_valid, m_halted, m_fault;

  always #5 clk = ~clk;

  assign inst_in  = (pc_addr <= 32'd1020) ? mem[pc_addr[9:2]] : 32'hDEAD_BEEF;
  assign pc_en_in = (inst_in != 32'h0);

  instr_fetch_unit #(.RESET_PC(32'h0), .MEM_BYTES(1024)) dut (
    .clk(clk), .rst(rst), .pc_addr(pc_addr), .inst_in(inst_in), .pc_en_in(pc_en_in),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .id_ready(id_ready), .id_valid(id_valid), .id_inst(id_inst), .id_pc(id_pc),
    .id_pc_plus4(id_pc_plus4), .halted(halted), .fault(fault), .fetch_count(fetch_count)
  );

  function automatic logic [31:0] word_at(input logic [31:0] a);
    if (a <= 32'd1020) return mem[a[9:2]];
    return 32'hDEAD_BEEF;
  endfunction

  task automatic model_reset();
    m_pc = 32'h0; m_inst = 0; m_id_pc = 0; m_plus4 = 0; m_count = 0;
    m_valid = 0; m_halted = 0; m_fault = 0;
  endtask

  task automatic model_step();
    logic [31:0] w;
    w = word_at(m_pc);
    if (m_fault || (m_halted && !redirect_valid)) begin
      if (id_ready) m_valid = 0;
    end else if (redirect_valid) begin
      m_halted = 0;
      m_pc     = {redirect_target[31:2], 2'b00};
      m_valid  = 0;
    end else if (m_pc > 32'd1020) begin
      m_fault = 1;
      if (id_ready) m_valid = 0;
    end else if (w == 32'h0) begin
      m_halted = 1;
      if (id_ready) m_valid = 0;
    end else if (!m_valid || id_ready) begin
      m_inst = w; m_id_pc = m_pc; m_plus4 = m_pc + 4;
      m_valid = 1; m_pc = m_pc + 4; m_count = m_count + 1;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #2;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic fill_mem(input int zero_idx);
    for (int i = 0; i < 256; i++) mem[i] = $urandom | 32'h1;
    if (zero_idx >= 0) mem[zero_idx] = 32'h0;
  endtask

  task automatic test_reset();
    n_checks++;
    if ({pc_addr, id_valid, id_inst, id_pc, id_pc_plus4, halted, fault, fetch_count} !==
        {32'h0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0}) begin
      n_fail++;
      $display("FAIL reset_state: got pc=%h v=%b inst=%h idpc=%h p4=%h h=%b f=%b cnt=%0d want all zero",
               pc_addr, id_valid, id_inst, id_pc, id_pc_plus4, halted, fault, fetch_count);
    end
  endtask

  task automatic test_program();
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[0] = 32'h0090_0513; mem[1] = 32'h0060_0593; mem[2] = 32'h00b5_0633; mem[3] = 32'h0;
    id_ready = 1; redirect_valid = 0;
    do_reset();
    for (int k = 0; k < 3; k++) begin
      tick();
      n_checks++;
      if (!id_valid || id_pc !== 32'(4 * k) || id_inst !== mem[k] || id_pc_plus4 !== 32'(4 * k + 4)) begin
        n_fail++;
        $display("FAIL prog_seq%0d: got v=%b pc=%h inst=%h p4=%h want pc=%h inst=%h",
                 k, id_valid, id_pc, id_inst, id_pc_plus4, 4 * k, mem[k]);
      end
    end
    repeat (2) tick();
    n_checks++;
    if (halted !== 1'b1 || pc_addr !== 32'd12 || fetch_count !== 32'd3 || id_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL prog_halt: got h=%b pc=%h cnt=%0d v=%b want h=1 pc=c cnt=3 v=0",
               halted, pc_addr, fetch_count, id_valid);
    end
  endtask

  task automatic test_stall();
    fill_mem(20);
    id_ready = 1; redirect_valid = 0;
    do_reset();
    repeat (2) tick();
    id_ready = 0;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_checks++;
      if (!id_valid || id_pc !== 32'd4 || id_inst !== mem[1] || pc_addr !== 32'd8) begin
        n_fail++;
        $display("FAIL stall_hold%0d: got v=%b idpc=%h inst=%h pc=%h want idpc=4 inst=%h pc=8",
                 k, id_valid, id_pc, id_inst, pc_addr, mem[1]);
      end
    end
    id_ready = 1;
    tick();
    n_checks++;
    if (!id_valid || id_pc !== 32'd8 || id_inst !== mem[2]) begin
      n_fail++;
      $display("FAIL stall_resume: got v=%b idpc=%h inst=%h want idpc=8 inst=%h",
               id_valid, id_pc, id_inst, mem[2]);
    end
  endtask

  task automatic test_redirect();
    fill_mem(-1);
    id_ready = 1; redirect_valid = 0;
    do_reset();
    repeat (2) tick();
    id_ready = 0; redirect_valid = 1; redirect_target = 32'h0000_0013;
    tick();
    redirect_valid = 0;
    n_checks++;
    if (id_valid !== 1'b0 || pc_addr !== 32'h10 || fetch_count !== 32'd2) begin
      n_fail++;
      $display("FAIL redir_flush: got v=%b pc=%h cnt=%0d want v=0 pc=10 cnt=2", id_valid, pc_addr, fetch_count);
    end
    tick();
    n_checks++;
    if (id_valid !== 1'b1 || id_pc !== 32'h10 || id_inst !== mem[4]) begin
      n_fail++;
      $display("FAIL redir_target: got v=%b idpc=%h inst=%h want idpc=10 inst=%h",
               id_valid, id_pc, id_inst, mem[4]);
    end
  endtask

  task automatic test_redirect_halt();
    fill_mem(3);
    mem[10] = 32'h0;
    id_ready = 1; redirect_valid = 0;
    do_reset();
    repeat (3) tick();
    redirect_valid = 1; redirect_target = 32'h20;
    tick();
    redirect_valid = 0;
    n_checks++;
    if (halted !== 1'b0 || pc_addr !== 32'h20) begin
      n_fail++;
      $display("FAIL redir_vs_term: got h=%b pc=%h want h=0 pc=20", halted, pc_addr);
    end
    repeat (4) tick();
    n_checks++;
    if (halted !== 1'b1 || pc_addr !== 32'h28 || id_pc !== 32'h24) begin
      n_fail++;
      $display("FAIL halt_at_28: got h=%b pc=%h idpc=%h want h=1 pc=28 idpc=24", halted, pc_addr, id_pc);
    end
    redirect_valid = 1; redirect_target = 32'h5;
    tick();
    redirect_valid = 0;
    n_checks++;
    if (halted !== 1'b0 || pc_addr !== 32'h4 || id_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL halt_redir: got h=%b pc=%h v=%b want h=0 pc=4 v=0", halted, pc_addr, id_valid);
    end
    tick();
    n_checks++;
    if (id_valid !== 1'b1 || id_pc !== 32'h4) begin
      n_fail++;
      $display("FAIL halt_resume: got v=%b idpc=%h want v=1 idpc=4", id_valid, id_pc);
    end
  endtask

  task automatic test_fault();
    fill_mem(-1);
    id_ready = 1; redirect_valid = 0;
    do_reset();
    repeat (256) tick();
    n_checks++;
    if (fault !== 1'b0 || id_pc !== 32'd1020 || pc_addr !== 32'd1024) begin
      n_fail++;
      $display("FAIL fault_edge: got f=%b idpc=%h pc=%h want f=0 idpc=3fc pc=400", fault, id_pc, pc_addr);
    end
    tick();
    n_checks++;
    if (fault !== 1'b1 || id_valid !== 1'b0 || id_pc !== 32'd1020 || fetch_count !== 32'd256) begin
      n_fail++;
      $display("FAIL fault_set: got f=%b v=%b idpc=%h cnt=%0d want f=1 v=0 idpc=3fc cnt=256",
               fault, id_valid, id_pc, fetch_count);
    end
    redirect_valid = 1; redirect_target = 32'h0;
    tick();
    redirect_valid = 0;
    tick();
    n_checks++;
    if (fault !== 1'b1 || pc_addr !== 32'd1024 || id_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL fault_sticky: got f=%b pc=%h v=%b want f=1 pc=400 v=0", fault, pc_addr, id_valid);
    end
  endtask

  task automatic test_async_reset();
    fill_mem(-1);
    id_ready = 1; redirect_valid = 0;
    do_reset();
    repeat (5) tick();
    #3;
    rst = 1'b1;
    #1;
    n_checks++;
    if ({pc_addr, id_valid, id_inst, id_pc, id_pc_plus4, halted, fault, fetch_count} !==
        {32'h0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0}) begin
      n_fail++;
      $display("FAIL async_reset: got pc=%h v=%b idpc=%h cnt=%0d want all zero",
               pc_addr, id_valid, id_pc, fetch_count);
    end
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_random();
    for (int i = 0; i < 256; i++) mem[i] = ($urandom_range(0, 7) == 0) ? 32'h0 : ($urandom | 32'h1);
    id_ready = 1; redirect_valid = 0;
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      id_ready        = ($urandom_range(0, 3) != 0);
      redirect_valid  = ($urandom_range(0, 11) == 0);
      redirect_target = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 1100));
      tick();
      n_checks++;
      if ({pc_addr, id_valid, id_inst, id_pc, id_pc_plus4, halted, fault, fetch_count} !==
          {m_pc, m_valid, m_inst, m_id_pc, m_plus4, m_halted, m_fault, m_count}) begin
        n_fail++;
        $display("FAIL rand_c%0d: got pc=%h v=%b inst=%h idpc=%h p4=%h h=%b f=%b cnt=%0d want pc=%h v=%b inst=%h idpc=%h p4=%h h=%b f=%b cnt=%0d",
                 c, pc_addr, id_valid, id_inst, id_pc, id_pc_plus4, halted, fault, fetch_count,
                 m_pc, m_valid, m_inst, m_id_pc, m_plus4, m_halted, m_fault, m_count);
      end
      if (m_fault && $urandom_range(0, 15) == 0) begin
        redirect_valid = 0;
        do_reset();
      end
    end
  endtask

  initial begin
    rst = 1'b1; id_ready = 1'b0; redirect_valid = 1'b0; redirect_target = 32'h0;
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    model_reset();
    #2;
    test_reset();
    #10;
    rst = 1'b0;
    test_program();
    test_stall();
    test_redirect();
    test_redirect_halt();
    test_fault();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
